// File: rtl/ctrl_pkg.sv
// Shared pipeline-control definitions: hazard FSM states, forwarding selects and
// opcode constants used by the hazard controller and the decoders.
package ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle: stage control/indices in, selects and
// stall/flush enables out. The pipeline is master, the controller is slave.
interface hazard_ctrl_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned PERF_W = 16
);
  logic [REG_AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic              ResultSrcE, PCSrcE, RegWriteM, RegWriteW, MemReqM, dmem_ready;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              StallF, StallD, StallE, StallM;
  logic              FlushD, FlushE, FlushW;
  logic              mem_timeout;
  logic [PERF_W-1:0] stall_cnt;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output ResultSrcE, PCSrcE, RegWriteM, RegWriteW, MemReqM, dmem_ready,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    input  FlushD, FlushE, FlushW, mem_timeout, stall_cnt
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  ResultSrcE, PCSrcE, RegWriteM, RegWriteW, MemReqM, dmem_ready,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    output FlushD, FlushE, FlushW, mem_timeout, stall_cnt
  );
endinterface

// File: rtl/fwd_unit.sv
// Combinational ALU operand forwarding: the M-stage result wins over the W-stage
// result; x0 is never forwarded.
module fwd_unit
  import ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic              RegWriteM,
  input  logic [REG_AW-1:0] RdM,
  input  logic              RegWriteW,
  input  logic [REG_AW-1:0] RdW,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE
);

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
    if (RegWriteM && (RdM != '0) && (RdM == rs)) begin
      return FWD_M;
    end else if (RegWriteW && (RdW != '0) && (RdW == rs)) begin
      return FWD_W;
    end
    return FWD_RF;
  endfunction

  always_comb begin
    ForwardAE = fwd_sel(Rs1E);
    ForwardBE = fwd_sel(Rs2E);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and stall sequencer for the 5-stage core: load-use stalls, branch
// flushes, whole-pipeline hold on slow data memory, sticky timeout, stall counter.
module hazard_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned PERF_W      = 16
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave bus
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic [PERF_W-1:0] stall_cnt_q;
  logic [1:0]        fwd_a, fwd_b;
  logic              lw_stall, hold, stall_any;

  fwd_unit #(
    .REG_AW(REG_AW)
  ) u_fwd (
    .RegWriteM(bus.RegWriteM),
    .RdM      (bus.RdM),
    .RegWriteW(bus.RegWriteW),
    .RdW      (bus.RdW),
    .Rs1E     (bus.Rs1E),
    .Rs2E     (bus.Rs2E),
    .ForwardAE(fwd_a),
    .ForwardBE(fwd_b)
  );

  always_comb begin
    state_d         = state_q;
    wait_d          = wait_q;
    hold            = 1'b0;
    bus.ForwardAE   = fwd_a;
    bus.ForwardBE   = fwd_b;
    bus.StallF      = 1'b0;
    bus.StallD      = 1'b0;
    bus.StallE      = 1'b0;
    bus.StallM      = 1'b0;
    bus.FlushD      = 1'b0;
    bus.FlushE      = 1'b0;
    bus.FlushW      = 1'b0;
    bus.mem_timeout = 1'b0;
    lw_stall = bus.ResultSrcE && (bus.RdE != '0) &&
               ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D));

    // Priority: memory hold > branch flush > load-use stall.
    unique case (state_q)
      RUN: begin
        if (bus.MemReqM && !bus.dmem_ready) begin
          hold    = 1'b1;
          state_d = MEM_WAIT;
          wait_d  = CNT_W'(1);
        end else if (bus.PCSrcE) begin
          bus.FlushD = 1'b1;
          bus.FlushE = 1'b1;
        end else if (lw_stall) begin
          bus.StallF = 1'b1;
          bus.StallD = 1'b1;
          bus.FlushE = 1'b1;
        end
      end
      MEM_WAIT: begin
        hold = 1'b1;
        if (bus.dmem_ready) begin
          state_d = RUN;
          wait_d  = '0;
        end else if (wait_q == CNT_W'(TIMEOUT_CYC)) begin
          state_d = ERROR;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      ERROR: begin
        hold            = 1'b1;
        bus.mem_timeout = 1'b1;
      end
      default: state_d = RUN;
    endcase

    if (hold) begin
      bus.StallF = 1'b1;
      bus.StallD = 1'b1;
      bus.StallE = 1'b1;
      bus.StallM = 1'b1;
      bus.FlushW = 1'b1;
    end

    // Every output reads zero while reset is held, forwarding included.
    if (!rst) begin
      bus.ForwardAE   = FWD_RF;
      bus.ForwardBE   = FWD_RF;
      bus.StallF      = 1'b0;
      bus.StallD      = 1'b0;
      bus.StallE      = 1'b0;
      bus.StallM      = 1'b0;
      bus.FlushD      = 1'b0;
      bus.FlushE      = 1'b0;
      bus.FlushW      = 1'b0;
      bus.mem_timeout = 1'b0;
    end

    stall_any     = bus.StallF | bus.StallD | bus.StallE | bus.StallM;
    bus.stall_cnt = stall_cnt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      wait_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (stall_any && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + PERF_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random
// stimulus compared against a cycle-level behavioural model.
module tb_hazard_ctrl;
  import ctrl_pkg::*;

  localparam int unsigned REG_AW      = 5;
  localparam int unsigned TIMEOUT_CYC = 4;
  localparam int unsigned CNT_W       = 8;
  localparam int unsigned PERF_W      = 4;
  localparam int          MODE_RUN    = 0;
  localparam int          MODE_WAIT   = 1;
  localparam int          MODE_ERR    = 2;
  localparam int          CNT_MAX     = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   m_mode;
  int   m_waited;
  int   m_stalls;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_AW(REG_AW), .PERF_W(PERF_W)) bus ();

  hazard_ctrl #(
    .REG_AW     (REG_AW),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .CNT_W      (CNT_W),
    .PERF_W     (PERF_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // {FwdA, FwdB, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, timeout, cnt}
  function automatic logic [15:0] got_outs();
    return {bus.ForwardAE, bus.ForwardBE, bus.StallF, bus.StallD, bus.StallE, bus.StallM,
            bus.FlushD, bus.FlushE, bus.FlushW, bus.mem_timeout, bus.stall_cnt};
  endfunction

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (bus.RegWriteM && bus.RdM != 0 && bus.RdM == rs) return 2'b10;
    if (bus.RegWriteW && bus.RdW != 0 && bus.RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [15:0] ref_outs();
    logic [15:0] o;
    logic        mem_hold, lw;
    o = '0;
    if (!rst) return o;
    o[15:14] = ref_fwd(bus.Rs1E);
    o[13:12] = ref_fwd(bus.Rs2E);
    mem_hold = (m_mode != MODE_RUN) || (bus.MemReqM && !bus.dmem_ready);
    lw = bus.ResultSrcE && bus.RdE != 0 && (bus.RdE == bus.Rs1D || bus.RdE == bus.Rs2D);
    if (mem_hold) begin
      o[11:8] = 4'hf;
      o[5]    = 1'b1;
    end else if (bus.PCSrcE) begin
      o[7] = 1'b1;
      o[6] = 1'b1;
    end else if (lw) begin
      o[11] = 1'b1;
      o[10] = 1'b1;
      o[6]  = 1'b1;
    end
    o[4]   = (m_mode == MODE_ERR);
    o[3:0] = 4'(m_stalls);
    return o;
  endfunction

  task automatic model_reset();
    m_mode   = MODE_RUN;
    m_waited = 0;
    m_stalls = 0;
  endtask

  // Advance the model across one rising edge using the inputs present at the edge.
  task automatic model_edge();
    logic [15:0] o;
    if (!rst) begin
      model_reset();
      return;
    end
    o = ref_outs();
    if (|o[11:8] && m_stalls < CNT_MAX) m_stalls++;
    case (m_mode)
      MODE_RUN: begin
        if (bus.MemReqM && !bus.dmem_ready) begin
          m_mode   = MODE_WAIT;
          m_waited = 1;
        end
      end
      MODE_WAIT: begin
        if (bus.dmem_ready) m_mode = MODE_RUN;
        else if (m_waited == int'(TIMEOUT_CYC)) m_mode = MODE_ERR;
        else m_waited++;
      end
      default: ;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    bus.Rs1D = '0; bus.Rs2D = '0; bus.Rs1E = '0; bus.Rs2E = '0;
    bus.RdE = '0; bus.RdM = '0; bus.RdW = '0;
    bus.ResultSrcE = 1'b0; bus.PCSrcE = 1'b0; bus.RegWriteM = 1'b0; bus.RegWriteW = 1'b0;
    bus.MemReqM = 1'b0; bus.dmem_ready = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;
    model_reset();
    #3 check_eq("rst_outs", 32'(got_outs()), 32'h0);
    tick();
    tick();
    rst = 1'b1;

    // Reset taken in the middle of a memory wait
    bus.MemReqM = 1'b1;
    tick();
    tick();
    check_eq("wait_stallm", 32'(bus.StallM), 32'd1);
    rst = 1'b0;
    model_reset();
    #1 check_eq("rst_mid_wait", 32'(got_outs()), 32'h0);
    tick();
    bus.MemReqM = 1'b0;
    rst = 1'b1;
    #1 check_eq("run_after_rst", 32'({bus.StallF, bus.StallD, bus.StallE, bus.StallM,
                                      bus.FlushW}), 32'h0);

    // Forwarding priority
    bus.RegWriteM = 1'b1; bus.RdM = 5'd5; bus.RegWriteW = 1'b1; bus.RdW = 5'd5;
    bus.Rs1E = 5'd5;
    #1 check_eq("fwd_m", 32'(bus.ForwardAE), 32'h2);
    bus.RdM = 5'd0;
    #1 check_eq("fwd_w_rdm0", 32'(bus.ForwardAE), 32'h1);
    bus.Rs2E = 5'd5;
    #1 check_eq("fwd_b_w", 32'(bus.ForwardBE), 32'h1);
    bus.RdW = 5'd0;
    #1 check_eq("fwd_rf_x0", 32'({bus.ForwardAE, bus.ForwardBE}), 32'h0);
    clear_inputs();
    tick();

    // Load-use stall for a single cycle
    bus.ResultSrcE = 1'b1; bus.RdE = 5'd3; bus.Rs2D = 5'd3;
    #1 check_eq("lu_ctrl", 32'({bus.StallF, bus.StallD, bus.FlushE, bus.StallE}), 32'hE);
    check_eq("lu_cnt0", 32'(bus.stall_cnt), 32'd0);
    tick();
    bus.ResultSrcE = 1'b0;
    #1 check_eq("lu_cnt1", 32'(bus.stall_cnt), 32'd1);
    check_eq("lu_release", 32'(bus.StallF), 32'd0);

    // Branch overrides load-use
    bus.ResultSrcE = 1'b1; bus.PCSrcE = 1'b1;
    #1 check_eq("br_over_lu", 32'({bus.FlushD, bus.FlushE, bus.StallF, bus.StallD}), 32'hC);
    tick();
    clear_inputs();
    #1 check_eq("br_nocnt", 32'(bus.stall_cnt), 32'd1);

    // Memory wait of 3 cycles with a branch held in E
    bus.MemReqM = 1'b1; bus.PCSrcE = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.dmem_ready = (i == 3);
      if (i == 4) bus.MemReqM = 1'b0;
      #1 check_eq("mw_hold", 32'({bus.StallF, bus.StallD, bus.StallE, bus.StallM, bus.FlushW}),
                  (i < 4) ? 32'h1f : 32'h0);
      check_eq("mw_flushd", 32'(bus.FlushD), (i == 4) ? 32'd1 : 32'd0);
      tick();
    end
    check_eq("mw_cnt", 32'(bus.stall_cnt), 32'd5);

    // Timeout into sticky ERROR, then saturation of the stall counter
    clear_inputs();
    bus.MemReqM = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1 check_eq("to_flag", 32'(bus.mem_timeout), (i == 5) ? 32'd1 : 32'd0);
      check_eq("to_stall", 32'(bus.StallF), 32'd1);
      tick();
    end
    bus.MemReqM = 1'b0; bus.dmem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1 check_eq("err_sticky", 32'({bus.mem_timeout, bus.StallM, bus.FlushW}), 32'h7);
      tick();
    end
    check_eq("stall_sat", 32'(bus.stall_cnt), 32'd15);
    tick();
    check_eq("stall_nowrap", 32'(bus.stall_cnt), 32'd15);
    rst = 1'b0;
    model_reset();
    #1 check_eq("rst_clr_err", 32'(got_outs()), 32'h0);
    tick();
    rst = 1'b1;
    clear_inputs();
    #1 check_eq("err_cleared", 32'(bus.mem_timeout), 32'd0);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      bus.Rs1D = 5'($urandom_range(0, 3)); bus.Rs2D = 5'($urandom_range(0, 3));
      bus.Rs1E = 5'($urandom_range(0, 3)); bus.Rs2E = 5'($urandom_range(0, 3));
      bus.RdE  = 5'($urandom_range(0, 3)); bus.RdM  = 5'($urandom_range(0, 3));
      bus.RdW  = 5'($urandom_range(0, 3));
      bus.ResultSrcE = ($urandom_range(0, 99) < 40);
      bus.PCSrcE     = ($urandom_range(0, 99) < 20);
      bus.RegWriteM  = ($urandom_range(0, 99) < 60);
      bus.RegWriteW  = ($urandom_range(0, 99) < 60);
      bus.MemReqM    = ($urandom_range(0, 99) < 30);
      bus.dmem_ready = ($urandom_range(0, 99) < 45);
      if ($urandom_range(0, 99) < 3) begin
        rst = 1'b0;
        model_reset();
      end else begin
        rst = 1'b1;
      end
      #1 check_eq("rand", 32'(got_outs()), 32'(ref_outs()));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and stall sequencer for the 5-stage RV32I core.
- Takes decoded control (RegWrite, ResultSrc, memory request) and register indices from the D/E/M/W stages.
- Produces operand forwarding selects and stall/flush enables for the pipeline registers.
- Holds the whole pipeline while a data-memory access is outstanding, and raises a sticky timeout error.

Parameters:
- REG_AW, 5, register-address width.
- TIMEOUT_CYC, 255, maximum number of MEM_WAIT cycles before the controller enters ERROR (range 1..2^CNT_W-1).
- CNT_W, 8, width of the wait counter.
- PERF_W, 16, width of the stall-cycle performance counter.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-low reset.
- Rs1D, Rs2D  in  REG_AW  source registers in Decode.
- Rs1E, Rs2E, RdE  in  REG_AW  source and destination registers in Execute.
- ResultSrcE  in  1  Execute holds a load.
- PCSrcE  in  1  branch taken, resolved in Execute.
- RdM, RdW  in  REG_AW  destination registers in Memory and Writeback.
- RegWriteM, RegWriteW  in  1  register-write enables in M and W.
- MemReqM  in  1  load or store present in Memory.
- dmem_ready  in  1  data memory completes the access this cycle.
- ForwardAE, ForwardBE  out  2  ALU operand select: 00 = register file, 01 = W result, 10 = M ALU result.
- StallF, StallD, StallE, StallM  out  1  hold the corresponding pipeline register.
- FlushD, FlushE, FlushW  out  1  clear the corresponding pipeline register to a bubble.
- mem_timeout  out  1  sticky error flag.
- stall_cnt  out  PERF_W  saturating count of stalled cycles.

Behaviour:
- Reset: while rst = 0, state = RUN, wait_cnt = 0, stall_cnt = 0, and every output is 0. Reset is effective mid-operation, including from ERROR.
- Output timing: all outputs are combinational from the current state and inputs (zero latency); state and counters are registered.
- Forwarding (every state):
  - ForwardAE = 10 if RegWriteM && RdM != 0 && RdM == Rs1E.
  - Otherwise ForwardAE = 01 if RegWriteW && RdW != 0 && RdW == Rs1E.
  - Otherwise ForwardAE = 00.
  - ForwardBE is identical using Rs2E. M has priority over W.
- State RUN:
  - Load-use: lwStall = ResultSrcE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D).
  - lwStall gives StallF = StallD = 1 and FlushE = 1.
  - PCSrcE gives FlushD = FlushE = 1 and suppresses lwStall.
  - If MemReqM && !dmem_ready: enter MEM_WAIT this cycle.
    - StallF/D/E/M = 1 and FlushW = 1 are asserted immediately.
    - FlushD, FlushE and lwStall outputs are suppressed.
    - wait_cnt <= 1.
  - A MemReqM that completes in the same cycle (dmem_ready = 1) causes no stall.
- State MEM_WAIT:
  - StallF/D/E/M = 1, FlushW = 1, no other flushes. A branch held in E is acted on once back in RUN.
  - dmem_ready = 1: go to RUN next cycle; this cycle still stalls; wait_cnt <= 0.
  - Otherwise, if wait_cnt == TIMEOUT_CYC: go to ERROR.
  - Otherwise wait_cnt increments.
- State ERROR:
  - StallF/D/E/M = 1, FlushW = 1, mem_timeout = 1.
  - Exit only via reset; dmem_ready is ignored.
- stall_cnt:
  - Increments on every cycle where any Stall* output is 1.
  - Saturates at 2^PERF_W - 1; never wraps.
- Simultaneous events:
  - Memory wait overrides branch flush and load-use stall.
  - Branch flush overrides load-use stall.
  - Forwarding is independent of all other logic.

Decomposition:
- Shared package ctrl_pkg holds:
  - state enum {RUN, MEM_WAIT, ERROR}.
  - FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10.
  - Opcode constants for load/store/R-type/branch, shared with the decoders.
- One natural sub-module, fwd_unit: purely combinational, computes ForwardAE/ForwardBE, instantiated once.
- The FSM and counters stay in hazard_ctrl.

Test Plan:
- Reset/forwarding: assert rst = 0 mid-MEM_WAIT -> all outputs 0, state RUN. Then RegWriteM = 1, RdM = 5, RegWriteW = 1, RdW = 5, Rs1E = 5 -> ForwardAE = 10. Same with RdM = 0 -> ForwardAE = 01.
- Load-use: ResultSrcE = 1, RdE = 3, Rs2D = 3 -> StallF = StallD = FlushE = 1 for exactly that cycle; stall_cnt goes 0 -> 1.
- Branch vs load-use: the load-use case plus PCSrcE = 1 -> FlushD = FlushE = 1, StallF = StallD = 0.
- Memory wait: MemReqM = 1, dmem_ready low for 3 cycles then high -> StallF/D/E/M and FlushW high for 4 cycles, RUN on the 5th. PCSrcE = 1 throughout -> FlushD stays 0 until RUN.
- Timeout: TIMEOUT_CYC = 4, dmem_ready held 0 -> ERROR entered after 4 MEM_WAIT cycles, mem_timeout = 1. A later dmem_ready = 1 has no effect; rst = 0 clears it.
- Saturation: PERF_W = 4, 20 stall cycles -> stall_cnt = 15.
